uart_tx_scheduler: RTL and testbench
====================================

// Module: uart_tx_scheduler
// PURPOSE
//   Shares the single UART transmitter between two byte sources: the RX echo path (priority) and a status/message
//   source. Sequences each byte into the transmitter (start pulse, wait busy rise/fall) and expands echoed CR (0x0D)
//   to CR+LF (0x0D,0x0A). Sits between the UART receiver/status logic and the UART TX shifter in the mirror top.
// PARAMETERS
//   CRLF_EXPAND     1       1: append 0x0A after every echoed 0x0D; 0: pass bytes unchanged
//   STARVE_LIMIT    4       consecutive echo grants allowed while stat_valid is high before status wins (1..15)
//   TIMEOUT_CYCLES  1200    cycles to wait for tx_busy to rise after tx_start (100 us at 12 MHz); width = clog2
// PORTS
//   clk          in   1  system clock (12 MHz)
//   rst          in   1  synchronous, active-high reset
//   echo_data    in   8  echo byte
//   echo_valid   in   1  echo byte available; hold until accepted
//   echo_ready   out  1  echo byte accepted this cycle (valid&&ready)
//   stat_data    in   8  status byte
//   stat_valid   in   1  status byte available; hold until accepted
//   stat_ready   out  1  status byte accepted this cycle
//   tx_data      out  8  byte to transmitter; stable from LAUNCH until WAIT_DONE exits
//   tx_start     out  1  one-cycle start pulse to transmitter
//   tx_busy      in   1  transmitter shifting (start..stop bit)
//   grant_owner  out  1  0=echo, 1=status owns current/last transfer
//   timeout_err  out  1  sticky: transmitter never went busy; cleared only by rst
// BEHAVIOUR
//   Reset: state IDLE; tx_data=0x00, tx_start=0, echo_ready=0, stat_ready=0, grant_owner=0, timeout_err=0,
//     starve_cnt=0, timeout counter=0, lf_pending=0. rst mid-transfer aborts: no further tx_start, pending LF dropped.
//   FSM: IDLE -> LAUNCH -> WAIT_BUSY -> WAIT_DONE -> (LAUNCH for LF | IDLE).
//   IDLE: arbitrates only when tx_busy==0. Echo wins if echo_valid && !(stat_valid && starve_cnt==STARVE_LIMIT);
//     else status wins if stat_valid. Winner's ready is combinational high this cycle (state==IDLE, !tx_busy);
//     on that edge: tx_data<=winner data, grant_owner<=winner, lf_pending<=CRLF_EXPAND && echo && data==0x0D, ->LAUNCH.
//     Never both readys high in one cycle.
//   starve_cnt: +1 (saturating) on echo grant while stat_valid==1; reset to 0 on status grant or when stat_valid==0.
//   LAUNCH: tx_start=1 for exactly one cycle; clear timeout counter; ->WAIT_BUSY.
//   Latency: acceptance edge in cycle N -> tx_start high in cycle N+1.
//   WAIT_BUSY: tx_busy==1 -> WAIT_DONE. Counter reaches TIMEOUT_CYCLES-1 first -> timeout_err<=1, lf_pending<=0,
//     ->IDLE (byte dropped). If tx_busy already high in LAUNCH cycle, WAIT_BUSY exits next cycle.
//   WAIT_DONE: no timeout; on tx_busy==0: lf_pending ? (tx_data<=0x0A, lf_pending<=0, ->LAUNCH) : ->IDLE.
//     LF is atomic with its CR: no source accepted between them; grant_owner stays 0.
//   Back-to-back: earliest next accept is the cycle after WAIT_DONE returns to IDLE (tx_busy low).
//   Valids dropping without handshake are ignored; data sampled only on the accept edge.
// TESTING
//   1 Reset: assert rst 3 cycles with both valids high -> all outputs at reset values, no ready, no tx_start.
//   2 Single echo 0x41, tx model busy 10 bit times (1.04 ms) -> echo_ready 1 cycle, tx_start 1 cycle later,
//     tx_data=0x41, back to IDLE after busy falls, grant_owner=0.
//   3 Echo 0x0D then 0x0A-free stream, CRLF_EXPAND=1 -> transmitter sees 0x0D,0x0A; stat_valid held high during
//     sequence is not accepted between CR and LF.
//   4 Both valids held continuously, STARVE_LIMIT=4 -> grant order E,E,E,E,S,E,E,E,E,S; starve_cnt resets on S.
//   5 Tx model never asserts busy -> timeout_err=1 exactly TIMEOUT_CYCLES after WAIT_BUSY entry, FSM IDLE,
//     next byte still accepted and sent; timeout_err remains 1 until rst.
//   6 rst pulsed during WAIT_DONE of echoed 0x0D -> no LF start pulse afterwards, outputs at reset values.

Source files
------------

// File: rtl/uart_tx_scheduler.sv
// ---------------------------------------------------------------------------
// uart_tx_scheduler
//
// Purpose:
//   Shares one UART transmitter between two byte sources. The RX echo path
//   normally has priority. The status/message source wins once the echo path
//   has taken STARVE_LIMIT grants in a row while status was waiting. Each
//   byte is sent to the transmitter as a one-cycle start pulse. The scheduler
//   then waits for the transmitter busy flag to rise and then fall. When
//   CRLF_EXPAND is set, every echoed CR (0x0D) is followed by an LF (0x0A).
//   The LF is sent as part of the same transfer, so no other source can be
//   accepted between the CR and its LF.
//
// Parameters:
//   CRLF_EXPAND     1: append 0x0A after every echoed 0x0D, 0: pass through
//   STARVE_LIMIT    consecutive echo grants allowed while status waits (1..15)
//   TIMEOUT_CYCLES  cycles to wait for i_tx_busy to rise after a start pulse
//
// Ports:
//   i_clk           system clock
//   i_rst           synchronous active-high reset
//   i_echo_data     echo byte
//   i_echo_valid    echo byte available, held until accepted
//   o_echo_ready    echo byte accepted this cycle (combinational)
//   i_stat_data     status byte
//   i_stat_valid    status byte available, held until accepted
//   o_stat_ready    status byte accepted this cycle (combinational)
//   o_tx_data       byte presented to the transmitter
//   o_tx_start      one-cycle start pulse to the transmitter
//   i_tx_busy       transmitter is shifting (start bit through stop bit)
//   o_grant_owner   0 = echo, 1 = status owns the current or last transfer
//   o_timeout_err   sticky flag: transmitter never went busy (cleared by i_rst)
// ---------------------------------------------------------------------------
module uart_tx_scheduler #(
    parameter int CRLF_EXPAND    = 1,
    parameter int STARVE_LIMIT   = 4,
    parameter int TIMEOUT_CYCLES = 1200
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic [7:0] i_echo_data,
    input  logic       i_echo_valid,
    output logic       o_echo_ready,
    input  logic [7:0] i_stat_data,
    input  logic       i_stat_valid,
    output logic       o_stat_ready,
    output logic [7:0] o_tx_data,
    output logic       o_tx_start,
    input  logic       i_tx_busy,
    output logic       o_grant_owner,
    output logic       o_timeout_err
);

    localparam int               TMO_W      = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TMO_W-1:0] TMO_LAST   = TMO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [3:0]       STARVE_MAX = 4'(STARVE_LIMIT);
    localparam logic [7:0]       CHAR_CR    = 8'h0D;
    localparam logic [7:0]       CHAR_LF    = 8'h0A;
    localparam bit               CRLF_EN    = (CRLF_EXPAND != 0);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        LAUNCH    = 2'd1,
        WAIT_BUSY = 2'd2,
        WAIT_DONE = 2'd3
    } state_t;

    state_t           r_state;
    state_t           w_state_next;
    logic [7:0]       r_tx_data;
    logic [7:0]       w_tx_data_next;
    logic             r_grant_owner;
    logic             w_grant_owner_next;
    logic             r_lf_pending;
    logic             w_lf_pending_next;
    logic             r_timeout_err;
    logic             w_timeout_err_next;
    logic [TMO_W-1:0] r_tmo_cnt;
    logic [TMO_W-1:0] w_tmo_cnt_next;
    logic [3:0]       r_starve_cnt;
    logic [3:0]       w_starve_cnt_next;

    logic             w_arb_ok;
    logic             w_stat_forced;
    logic             w_echo_grant;
    logic             w_stat_grant;

    // Arbitration only happens in IDLE while the transmitter is quiet. Reset
    // masks it, so no handshake is ever signalled while the block is held in
    // reset. Status is forced to win only after echo has used up its run of
    // grants. Otherwise echo has priority. The two grants are mutually
    // exclusive by construction.
    always_comb begin
        w_arb_ok      = (r_state == IDLE) && !i_tx_busy && !i_rst;
        w_stat_forced = i_stat_valid && (r_starve_cnt == STARVE_MAX);
        w_echo_grant  = w_arb_ok && i_echo_valid && !w_stat_forced;
        w_stat_grant  = w_arb_ok && i_stat_valid && !w_echo_grant;
    end

    // The starvation counter counts echo grants taken while status was
    // waiting. It clears as soon as status is served or stops asking. It
    // saturates at the limit, where status is guaranteed the next grant.
    always_comb begin
        w_starve_cnt_next = r_starve_cnt;
        if (w_stat_grant || !i_stat_valid) begin
            w_starve_cnt_next = 4'd0;
        end else if (w_echo_grant && (r_starve_cnt != STARVE_MAX)) begin
            w_starve_cnt_next = r_starve_cnt + 4'd1;
        end
    end

    // Next-state and datapath logic for the transfer sequencer.
    // A timeout in WAIT_BUSY drops the byte and any pending LF. WAIT_DONE
    // has no timeout, because a transmitter that has gone busy always
    // finishes its frame. A pending LF goes straight back to LAUNCH without
    // passing through IDLE, so no source is accepted between the CR and its LF.
    always_comb begin
        w_state_next       = r_state;
        w_tx_data_next     = r_tx_data;
        w_grant_owner_next = r_grant_owner;
        w_lf_pending_next  = r_lf_pending;
        w_timeout_err_next = r_timeout_err;
        w_tmo_cnt_next     = r_tmo_cnt;

        case (r_state)
            IDLE: begin
                if (w_echo_grant) begin
                    w_tx_data_next     = i_echo_data;
                    w_grant_owner_next = 1'b0;
                    w_lf_pending_next  = CRLF_EN && (i_echo_data == CHAR_CR);
                    w_state_next       = LAUNCH;
                end else if (w_stat_grant) begin
                    w_tx_data_next     = i_stat_data;
                    w_grant_owner_next = 1'b1;
                    w_lf_pending_next  = 1'b0;
                    w_state_next       = LAUNCH;
                end
            end

            LAUNCH: begin
                w_tmo_cnt_next = '0;
                w_state_next   = WAIT_BUSY;
            end

            WAIT_BUSY: begin
                if (i_tx_busy) begin
                    w_state_next = WAIT_DONE;
                end else if (r_tmo_cnt == TMO_LAST) begin
                    w_timeout_err_next = 1'b1;
                    w_lf_pending_next  = 1'b0;
                    w_state_next       = IDLE;
                end else begin
                    w_tmo_cnt_next = r_tmo_cnt + 1'b1;
                end
            end

            WAIT_DONE: begin
                if (!i_tx_busy) begin
                    if (r_lf_pending) begin
                        w_tx_data_next    = CHAR_LF;
                        w_lf_pending_next = 1'b0;
                        w_state_next      = LAUNCH;
                    end else begin
                        w_state_next = IDLE;
                    end
                end
            end

            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    // State and datapath registers. Reset aborts any transfer in progress
    // and discards a pending LF.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state       <= IDLE;
            r_tx_data     <= 8'h00;
            r_grant_owner <= 1'b0;
            r_lf_pending  <= 1'b0;
            r_timeout_err <= 1'b0;
            r_tmo_cnt     <= '0;
            r_starve_cnt  <= 4'd0;
        end else begin
            r_state       <= w_state_next;
            r_tx_data     <= w_tx_data_next;
            r_grant_owner <= w_grant_owner_next;
            r_lf_pending  <= w_lf_pending_next;
            r_timeout_err <= w_timeout_err_next;
            r_tmo_cnt     <= w_tmo_cnt_next;
            r_starve_cnt  <= w_starve_cnt_next;
        end
    end

    assign o_echo_ready  = w_echo_grant;
    assign o_stat_ready  = w_stat_grant;
    assign o_tx_start    = (r_state == LAUNCH);
    assign o_tx_data     = r_tx_data;
    assign o_grant_owner = r_grant_owner;
    assign o_timeout_err = r_timeout_err;

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// ---------------------------------------------------------------------------
// tb_uart_tx_scheduler
//
// Directed testbench for uart_tx_scheduler. Two queue-driven sources present
// bytes and hold valid until they are accepted. A small transmitter model
// raises busy one cycle after each start pulse and holds it for BUSY_LEN
// cycles, which stands in for a frame shortened from its real 10-bit length.
// The model can also be told never to go busy. A negedge monitor records the
// grant order, the acceptance cycles and any handshake anomalies.
// ---------------------------------------------------------------------------
module tb_uart_tx_scheduler;

    localparam int TMO      = 1200;
    localparam int STARVE   = 4;
    localparam int BUSY_LEN = 12;

    logic       i_clk = 1'b0;
    logic       i_rst = 1'b1;
    logic [7:0] i_echo_data = 8'h00;
    logic       i_echo_valid = 1'b0;
    logic       o_echo_ready;
    logic [7:0] i_stat_data = 8'h00;
    logic       i_stat_valid = 1'b0;
    logic       o_stat_ready;
    logic [7:0] o_tx_data;
    logic       o_tx_start;
    logic       i_tx_busy = 1'b0;
    logic       o_grant_owner;
    logic       o_timeout_err;

    uart_tx_scheduler #(
        .CRLF_EXPAND   (1),
        .STARVE_LIMIT  (STARVE),
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .i_clk        (i_clk),
        .i_rst        (i_rst),
        .i_echo_data  (i_echo_data),
        .i_echo_valid (i_echo_valid),
        .o_echo_ready (o_echo_ready),
        .i_stat_data  (i_stat_data),
        .i_stat_valid (i_stat_valid),
        .o_stat_ready (o_stat_ready),
        .o_tx_data    (o_tx_data),
        .o_tx_start   (o_tx_start),
        .i_tx_busy    (i_tx_busy),
        .o_grant_owner(o_grant_owner),
        .o_timeout_err(o_timeout_err)
    );

    always #5 i_clk = ~i_clk;

    int checkCount = 0;
    int passCount  = 0;
    int cyc        = 0;

    int echoQ[$];
    int statQ[$];
    int grantLog[$];
    int acceptCycles[$];
    int sentLog[$];
    int ownerLog[$];
    int startCycles[$];
    int fallCycles[$];

    bit autoDrive    = 1'b0;
    bit modelEnable  = 1'b1;
    bit echoTaken    = 1'b0;
    bit statTaken    = 1'b0;
    bit startPending = 1'b0;
    bit prevStart    = 1'b0;
    int busyCnt      = 0;
    int bothReady    = 0;
    int doubleStart  = 0;
    int echoReadyCycles = 0;

    // Count one comparison and report it when the observed value differs
    // from the required one.
    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checkCount++;
        if (actual === expected) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s: observed 0x%0h, required 0x%0h", tag, actual, expected);
        end
    endtask

    // Queue one byte on the echo source (isStat=0) or the status source (isStat=1).
    task automatic applyStimulus(input bit isStat, input logic [7:0] data);
        if (isStat) statQ.push_back(int'(data));
        else        echoQ.push_back(int'(data));
    endtask

    // Read a queue entry, returning -1 when the index is past the end.
    function automatic int at(input int q[$], input int idx);
        return (idx < q.size()) ? q[idx] : -1;
    endfunction

    task automatic clearLogs();
        grantLog.delete();
        acceptCycles.delete();
        sentLog.delete();
        ownerLog.delete();
        startCycles.delete();
        fallCycles.delete();
        echoReadyCycles = 0;
    endtask

    // Wait until both queues are empty and the transmitter has stayed quiet
    // for a few cycles. An expired budget counts as a failed check.
    task automatic waitDrain(input string tag, input int maxCycles);
        int quiet = 0;
        int n = 0;
        while (quiet < 4 && n < maxCycles) begin
            @(negedge i_clk);
            n++;
            if (echoQ.size() == 0 && statQ.size() == 0 && !i_tx_busy && !o_tx_start && !startPending)
                quiet++;
            else
                quiet = 0;
        end
        if (quiet < 4) checkOutput({tag, "_drain_timeout"}, 32'd0, 32'd1);
    endtask

    always @(posedge i_clk) cyc++;

    // Monitor: ready and start are sampled mid-cycle, well away from the edge.
    always @(negedge i_clk) begin
        if (o_echo_ready && o_stat_ready) bothReady++;
        if (o_tx_start && prevStart) doubleStart++;
        prevStart = o_tx_start;
        if (o_echo_ready) begin
            grantLog.push_back(0);
            acceptCycles.push_back(cyc);
            echoTaken = 1'b1;
            echoReadyCycles++;
        end
        if (o_stat_ready) begin
            grantLog.push_back(1);
            acceptCycles.push_back(cyc);
            statTaken = 1'b1;
        end
    end

    // Source driver: pops the accepted byte and presents the next one just after the edge.
    always @(posedge i_clk) begin
        int tmp;
        #1;
        if (echoTaken) begin tmp = echoQ.pop_front(); echoTaken = 1'b0; end
        if (statTaken) begin tmp = statQ.pop_front(); statTaken = 1'b0; end
        if (autoDrive) begin
            i_echo_valid = (echoQ.size() > 0);
            i_echo_data  = (echoQ.size() > 0) ? 8'(echoQ[0]) : 8'h00;
            i_stat_valid = (statQ.size() > 0);
            i_stat_data  = (statQ.size() > 0) ? 8'(statQ[0]) : 8'h00;
        end
    end

    // Transmitter model: busy rises in the cycle after the start pulse and
    // stays high for BUSY_LEN cycles.
    always @(posedge i_clk) begin
        #1;
        if (i_rst) begin
            i_tx_busy    = 1'b0;
            busyCnt      = 0;
            startPending = 1'b0;
        end else if (o_tx_start) begin
            sentLog.push_back(int'(o_tx_data));
            ownerLog.push_back(int'(o_grant_owner));
            startCycles.push_back(cyc);
            if (modelEnable) startPending = 1'b1;
        end else if (startPending) begin
            startPending = 1'b0;
            i_tx_busy    = 1'b1;
            busyCnt      = BUSY_LEN;
        end else if (busyCnt > 0) begin
            busyCnt--;
            if (busyCnt == 0) begin
                i_tx_busy = 1'b0;
                fallCycles.push_back(cyc);
            end
        end
    end

    initial begin
        int errCycle;
        int n;
        int startsAtRelease;

        // Reset held for three cycles with both sources asking.
        i_echo_valid = 1'b1;
        i_echo_data  = 8'h0D;
        i_stat_valid = 1'b1;
        i_stat_data  = 8'h53;
        for (int i = 0; i < 3; i++) begin
            @(negedge i_clk);
            checkOutput("rst_echo_ready", o_echo_ready, 0);
            checkOutput("rst_stat_ready", o_stat_ready, 0);
            checkOutput("rst_tx_start",   o_tx_start,   0);
        end
        i_echo_valid = 1'b0;
        i_stat_valid = 1'b0;
        @(negedge i_clk);
        i_rst = 1'b0;
        @(negedge i_clk);
        checkOutput("rst_tx_data",     o_tx_data,     8'h00);
        checkOutput("rst_grant_owner", o_grant_owner, 0);
        checkOutput("rst_timeout_err", o_timeout_err, 0);
        checkOutput("rst_no_start",    startCycles.size(), 0);
        autoDrive = 1'b1;

        // Single echo byte plus a back-to-back follower.
        clearLogs();
        applyStimulus(0, 8'h41);
        applyStimulus(0, 8'h42);
        waitDrain("t2", 300);
        checkOutput("t2_accepts",       acceptCycles.size(), 2);
        checkOutput("t2_ready_cycles",  echoReadyCycles, 2);
        checkOutput("t2_byte0",         at(sentLog, 0), 32'h41);
        checkOutput("t2_byte1",         at(sentLog, 1), 32'h42);
        checkOutput("t2_start_latency", at(startCycles, 0) - at(acceptCycles, 0), 1);
        checkOutput("t2_owner0",        at(ownerLog, 0), 0);
        checkOutput("t2_b2b_accept",    at(acceptCycles, 1), at(fallCycles, 0) + 1);
        checkOutput("t2_grant_owner",   o_grant_owner, 0);

        // CR expands to CR+LF, with status held waiting and not slipped in between.
        clearLogs();
        applyStimulus(1, 8'h53);
        applyStimulus(0, 8'h0D);
        applyStimulus(0, 8'h41);
        applyStimulus(0, 8'h42);
        waitDrain("t3", 400);
        checkOutput("t3_sent0",    at(sentLog, 0), 32'h0D);
        checkOutput("t3_sent1_lf", at(sentLog, 1), 32'h0A);
        checkOutput("t3_sent2",    at(sentLog, 2), 32'h41);
        checkOutput("t3_sent3",    at(sentLog, 3), 32'h42);
        checkOutput("t3_sent4",    at(sentLog, 4), 32'h53);
        checkOutput("t3_lf_owner", at(ownerLog, 1), 0);
        checkOutput("t3_st_owner", at(ownerLog, 4), 1);
        checkOutput("t3_accepts",  grantLog.size(), 4);
        checkOutput("t3_lf_start", at(startCycles, 1), at(fallCycles, 0) + 1);

        // Both sources saturated: the order must be E,E,E,E,S repeated.
        clearLogs();
        applyStimulus(1, 8'h60);
        applyStimulus(1, 8'h61);
        for (int i = 0; i < 10; i++) applyStimulus(0, 8'(8'h30 + i));
        waitDrain("t4", 800);
        for (int i = 0; i < 10; i++)
            checkOutput($sformatf("t4_grant%0d", i), at(grantLog, i), ((i % 5) == STARVE) ? 1 : 0);
        checkOutput("t4_stat0_data", at(sentLog, 4), 32'h60);
        checkOutput("t4_stat1_data", at(sentLog, 9), 32'h61);
        checkOutput("t4_total",      sentLog.size(), 12);

        // Transmitter never goes busy: timeout, drop, then recover.
        clearLogs();
        modelEnable = 1'b0;
        applyStimulus(0, 8'h55);
        applyStimulus(0, 8'h66);
        n = 0;
        errCycle = -1;
        while (!o_timeout_err && n < 3 * TMO) begin
            @(negedge i_clk);
            n++;
        end
        if (o_timeout_err) errCycle = cyc;
        else checkOutput("t5_err_wait_timeout", 32'd0, 32'd1);
        modelEnable = 1'b1;
        waitDrain("t5", 300);
        checkOutput("t5_err_timing",   errCycle - at(startCycles, 0), TMO + 1);
        checkOutput("t5_next_accept",  at(acceptCycles, 1), errCycle);
        checkOutput("t5_next_sent",    at(sentLog, 1), 32'h66);
        checkOutput("t5_next_done",    fallCycles.size(), 1);
        checkOutput("t5_err_sticky",   o_timeout_err, 1);

        // Reset during WAIT_DONE of a CR: the LF must never be launched.
        clearLogs();
        applyStimulus(0, 8'h0D);
        n = 0;
        while (!i_tx_busy && n < 100) begin
            @(negedge i_clk);
            n++;
        end
        if (!i_tx_busy) checkOutput("t6_busy_wait_timeout", 32'd0, 32'd1);
        @(negedge i_clk);
        @(negedge i_clk);
        i_rst = 1'b1;
        @(negedge i_clk);
        @(negedge i_clk);
        i_rst = 1'b0;
        startsAtRelease = startCycles.size();
        checkOutput("t6_tx_data",     o_tx_data,     8'h00);
        checkOutput("t6_grant_owner", o_grant_owner, 0);
        checkOutput("t6_timeout_err", o_timeout_err, 0);
        checkOutput("t6_tx_start",    o_tx_start,    0);
        repeat (40) @(negedge i_clk);
        checkOutput("t6_cr_sent",     at(sentLog, 0), 32'h0D);
        checkOutput("t6_no_lf",       startCycles.size(), 1);
        checkOutput("t6_no_new_start", startCycles.size() - startsAtRelease, 0);

        checkOutput("never_both_ready", bothReady, 0);
        checkOutput("start_one_cycle",  doubleStart, 0);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
